// File: rtl/timer_pkg.sv
// Shared definitions for the timer control slice: FSM state type and
// default widths used by timer_ctrl and its prescaler.
package timer_pkg;

    localparam int CNT_W_DEF   = 64;
    localparam int DIV_MAX_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler for the timer. It produces a combinational tick in
// the cycle where the counter should advance.
// - run:    the timer stays in RUN this cycle.
// - freeze: the timer is halting, halted or leaving halt, so the phase is kept.
// Any other cycle clears the phase. A change of div_en/div_val restarts the
// period and suppresses the tick for that cycle.
module timer_prescaler import timer_pkg::*; #(
    parameter int DIV_MAX = DIV_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       freeze,
    input  logic       div_en,
    input  logic [3:0] div_val,
    output logic       tick
);

    localparam int DW = DIV_MAX + 1;

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] terminal;
    logic          div_en_q;
    logic [3:0]    div_val_q;
    logic          cfg_changed;
    logic          bypass;
    logic          illegal;
    logic          at_terminal;

    // Decode the configuration and decide whether this cycle ends a period
    always_comb begin
        cfg_changed = (div_en != div_en_q) || (div_val != div_val_q);
        bypass      = !div_en || (div_val == 4'd0);
        illegal     = !bypass && (int'(div_val) > DIV_MAX);
        terminal    = (DW'(1) << div_val) - DW'(1);
        at_terminal = (div_cnt == terminal);
        tick        = 1'b0;
        if (run && !cfg_changed) begin
            if (bypass) begin
                tick = 1'b1;
            end else if (!illegal) begin
                tick = at_terminal;
            end
        end
    end

    // Advance, hold or clear the period phase, and remember the last configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            div_en_q  <= 1'b0;
            div_val_q <= 4'd0;
        end else begin
            div_en_q  <= div_en;
            div_val_q <= div_val;
            if ((run || freeze) && cfg_changed) begin
                div_cnt <= '0;
            end else if (run) begin
                if (bypass) begin
                    div_cnt <= div_cnt + 1'b1;
                end else if (illegal || at_terminal) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else if (!freeze) begin
                div_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Timer control: IDLE/RUN/HALT sequencing, prescaled increment strobe for an
// external counter, counter-clear pulse on disable, debug halt handshake and
// compare interrupt status.
module timer_ctrl import timer_pkg::*; #(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_MAX = DIV_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [3:0]       div_val,
    input  logic             halt_req,
    input  logic             int_en,
    input  logic             int_clr,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic [CNT_W-1:0] cmp_value,
    output logic             cnt_en,
    output logic             timer_en_H_L,
    output logic             valid_halt_condition,
    output logic             halt_ack,
    output logic             int_st,
    output logic             tim_int
);

    timer_state_t state;
    logic         timer_en_q;
    logic         run;
    logic         freeze;
    logic         tick;

    // run: RUN and staying there. freeze: heading into, sitting in or leaving HALT.
    assign run    = (state == ST_RUN) && timer_en && !halt_req;
    assign freeze = timer_en && (((state == ST_RUN) && halt_req) || (state == ST_HALT));

    timer_prescaler #(
        .DIV_MAX (DIV_MAX)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .freeze  (freeze),
        .div_en  (div_en),
        .div_val (div_val),
        .tick    (tick)
    );

    // Main FSM with registered strobe, clear pulse and halt handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            timer_en_q           <= 1'b0;
            timer_en_H_L         <= 1'b0;
            cnt_en               <= 1'b0;
            halt_ack             <= 1'b0;
            valid_halt_condition <= 1'b0;
        end else begin
            timer_en_q           <= timer_en;
            timer_en_H_L         <= timer_en_q & ~timer_en;
            cnt_en               <= tick;
            halt_ack             <= 1'b0;
            valid_halt_condition <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (timer_en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!timer_en) begin
                        state <= ST_IDLE;
                    end else if (halt_req) begin
                        state                <= ST_HALT;
                        halt_ack             <= 1'b1;
                        valid_halt_condition <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!timer_en) begin
                        state <= ST_IDLE;
                    end else if (!halt_req) begin
                        state <= ST_RUN;
                    end else begin
                        halt_ack             <= 1'b1;
                        valid_halt_condition <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Interrupt status: compare match while active sets it, int_clr clears it, set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_st <= 1'b0;
        end else if ((state != ST_IDLE) && (cnt_value == cmp_value)) begin
            int_st <= 1'b1;
        end else if (int_clr) begin
            int_st <= 1'b0;
        end
    end

    assign tim_int = int_st & int_en;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model.
module tb_timer_ctrl;

    localparam int CNT_W   = 64;
    localparam int DIV_MAX = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             timer_en = 1'b0;
    logic             div_en = 1'b0;
    logic [3:0]       div_val = 4'd0;
    logic             halt_req = 1'b0;
    logic             int_en = 1'b0;
    logic             int_clr = 1'b0;
    logic [CNT_W-1:0] cnt_value = '0;
    logic [CNT_W-1:0] cmp_value = '1;
    logic             cnt_en;
    logic             timer_en_H_L;
    logic             valid_halt_condition;
    logic             halt_ack;
    logic             int_st;
    logic             tim_int;

    int tests = 0;
    int failed = 0;

    // Behavioural model: mode 0 stopped, 1 counting, 2 halted
    int              m_mode;
    longint unsigned m_runs;
    longint unsigned m_count;
    bit              m_prev_en;
    bit [3:0]        m_prev_val;
    bit              m_te_prev;
    bit              e_cnt_en;
    bit              e_hl;
    bit              e_halt;
    bit              e_int_st;

    timer_ctrl #(
        .CNT_W   (CNT_W),
        .DIV_MAX (DIV_MAX)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .timer_en             (timer_en),
        .div_en               (div_en),
        .div_val              (div_val),
        .halt_req             (halt_req),
        .int_en               (int_en),
        .int_clr              (int_clr),
        .cnt_value            (cnt_value),
        .cmp_value            (cmp_value),
        .cnt_en               (cnt_en),
        .timer_en_H_L         (timer_en_H_L),
        .valid_halt_condition (valid_halt_condition),
        .halt_ack             (halt_ack),
        .int_st               (int_st),
        .tim_int              (tim_int)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] observed();
        return {cnt_en, timer_en_H_L, halt_ack, valid_halt_condition, int_st, tim_int};
    endfunction

    function automatic logic [5:0] expected();
        return {e_cnt_en, e_hl, e_halt, e_halt, e_int_st, e_int_st & int_en};
    endfunction

    function automatic void model_reset();
        m_mode     = 0;
        m_runs     = 0;
        m_count    = 0;
        m_prev_en  = 1'b0;
        m_prev_val = 4'd0;
        m_te_prev  = 1'b0;
        e_cnt_en   = 1'b0;
        e_hl       = 1'b0;
        e_halt     = 1'b0;
        e_int_st   = 1'b0;
    endfunction

    // One clock: model the edge from the spec rules, then settle at the falling edge
    task automatic step();
        longint unsigned period;
        bit              active;
        bit              changed;
        bit              tick;
        int              next_mode;
        @(posedge clk);
        if (!div_en || div_val == 4'd0)      period = 1;
        else if (int'(div_val) > DIV_MAX)    period = 0;
        else                                 period = longint'(1) << div_val;
        active  = (m_mode == 1) && timer_en && !halt_req;
        changed = (div_en != m_prev_en) || (div_val != m_prev_val);
        tick    = 1'b0;
        if (m_mode == 0 || changed || !timer_en) begin
            m_runs = 0;
        end else if (active) begin
            if (period == 0) begin
                m_runs = 0;
            end else begin
                m_runs++;
                tick = (m_runs % period) == 0;
            end
        end
        if (m_mode == 0) next_mode = timer_en ? 1 : 0;
        else             next_mode = !timer_en ? 0 : (halt_req ? 2 : 1);
        if (m_mode != 0 && cnt_value == cmp_value) e_int_st = 1'b1;
        else if (int_clr)                          e_int_st = 1'b0;
        if (e_hl)          m_count = 0;
        else if (e_cnt_en) m_count++;
        e_hl       = m_te_prev && !timer_en;
        m_te_prev  = timer_en;
        e_cnt_en   = tick;
        e_halt     = (next_mode == 2);
        m_mode     = next_mode;
        m_prev_en  = div_en;
        m_prev_val = div_val;
        @(negedge clk);
        cnt_value = m_count;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (observed() !== 6'b0) begin
            failed++;
            $display("[TB] FAIL reset_hold: got %b expected %b", observed(), 6'b0);
        end
        rst_n = 1'b1;
        timer_en = 1'b1; div_en = 1'b1; div_val = 4'd1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL reset_prerun[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
        halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL reset_halt[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
        tests++;
        if (halt_ack !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_halt_ack: got %b expected 1", halt_ack);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (observed() !== 6'b0) begin
            failed++;
            $display("[TB] FAIL reset_async: got %b expected %b", observed(), 6'b0);
        end
        model_reset();
        cnt_value = '0;
        timer_en = 1'b0; halt_req = 1'b0; div_en = 1'b0; div_val = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (timer_en_H_L !== 1'b0 || observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL reset_release[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_free_run();
        int highs = 0;
        timer_en = 1'b1; div_en = 1'b0; div_val = 4'd0;
        for (int i = 1; i <= 11; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL free_run[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (i == 1) begin
                tests++;
                if (cnt_en !== 1'b0) begin
                    failed++;
                    $display("[TB] FAIL free_run_entry: got %b expected 0", cnt_en);
                end
            end else if (cnt_en === 1'b1) begin
                highs++;
            end
        end
        tests++;
        if (highs != 10) begin
            failed++;
            $display("[TB] FAIL free_run_count: got %0d expected 10", highs);
        end
    endtask

    task automatic test_prescale();
        int first;
        int second;
        div_en = 1'b1; div_val = 4'd2;
        first = -1; second = -1;
        for (int i = 1; i <= 13; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL prescale2[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (cnt_en === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        tests++;
        if (first != 5 || second != 9) begin
            failed++;
            $display("[TB] FAIL prescale2_pulses: got %0d,%0d expected 5,9", first, second);
        end
        div_val = 4'd3;
        first = -1; second = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL prescale3[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (cnt_en === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        tests++;
        if (first != 9 || second != 17) begin
            failed++;
            $display("[TB] FAIL prescale3_pulses: got %0d,%0d expected 9,17", first, second);
        end
    endtask

    task automatic test_halt();
        int  found = -1;
        bit  bad_hold = 1'b0;
        div_val = 4'd2;
        for (int i = 1; i <= 10 && found < 0; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL halt_lead[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (cnt_en === 1'b1) found = i;
        end
        tests++;
        if (found != 5) begin
            failed++;
            $display("[TB] FAIL halt_lead_pulse: got %0d expected 5", found);
        end
        step();
        halt_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL halt_hold[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (halt_ack !== 1'b1 || valid_halt_condition !== 1'b1 || cnt_en !== 1'b0) bad_hold = 1'b1;
        end
        tests++;
        if (bad_hold) begin
            failed++;
            $display("[TB] FAIL halt_hold_outputs: got halt_ack=%b cnt_en=%b expected 1,0", halt_ack, cnt_en);
        end
        halt_req = 1'b0;
        found = -1;
        for (int i = 1; i <= 10 && found < 0; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL halt_resume[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (cnt_en === 1'b1) found = i;
        end
        tests++;
        if (found != 4) begin
            failed++;
            $display("[TB] FAIL halt_resume_pulse: got %0d expected 4", found);
        end
    endtask

    task automatic test_interrupt();
        int first_int = -1;
        timer_en = 1'b0; halt_req = 1'b0; div_en = 1'b0; div_val = 4'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL int_stop[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        cmp_value = 64'd5; int_en = 1'b1; timer_en = 1'b1;
        for (int i = 1; i <= 20 && first_int < 0; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL int_run[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (int_st === 1'b1) first_int = i;
        end
        tests++;
        if (first_int != 8 || tim_int !== 1'b1) begin
            failed++;
            $display("[TB] FAIL int_match: got edge %0d tim_int %b expected edge 8 tim_int 1", first_int, tim_int);
        end
        halt_req = 1'b1;
        repeat (3) step();
        cmp_value = cnt_value;
        int_clr = 1'b1;
        step();
        tests++;
        if (int_st !== 1'b1 || observed() !== expected()) begin
            failed++;
            $display("[TB] FAIL int_set_wins: got int_st %b expected 1", int_st);
        end
        cmp_value = cnt_value + 64'd100;
        step();
        int_clr = 1'b0;
        tests++;
        if (int_st !== 1'b0 || tim_int !== 1'b0) begin
            failed++;
            $display("[TB] FAIL int_clear: got %b%b expected 00", int_st, tim_int);
        end
    endtask

    task automatic test_halt_to_idle();
        int pulses = 0;
        timer_en = 1'b0;
        step();
        tests++;
        if (timer_en_H_L !== 1'b1 || halt_ack !== 1'b0 || valid_halt_condition !== 1'b0) begin
            failed++;
            $display("[TB] FAIL halt_to_idle: got hl=%b ack=%b expected hl=1 ack=0", timer_en_H_L, halt_ack);
        end
        step();
        tests++;
        if (timer_en_H_L !== 1'b0 || observed() !== expected()) begin
            failed++;
            $display("[TB] FAIL halt_to_idle_single: got %b expected %b", observed(), expected());
        end
        halt_req = 1'b0; div_en = 1'b1; div_val = 4'd9; timer_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL illegal_div[%0d]: got %b expected %b", i, observed(), expected());
            end
            if (cnt_en === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 0) begin
            failed++;
            $display("[TB] FAIL illegal_div_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            timer_en = ($urandom_range(0, 15) != 0);
            halt_req = ($urandom_range(0, 5) == 0);
            int_en   = $urandom_range(0, 1);
            int_clr  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) div_en = ~div_en;
            if ($urandom_range(0, 19) == 0) div_val = 4'($urandom_range(0, 10));
            if ($urandom_range(0, 9) == 0) cmp_value = cnt_value + 64'($urandom_range(0, 3));
            step();
            tests++;
            if (observed() !== expected()) begin
                failed++;
                $display("[TB] FAIL random[%0d]: got %b expected %b", i, observed(), expected());
            end
        end
    endtask

    // Sequence all scenarios and report
    initial begin
        test_reset();
        test_free_run();
        test_prescale();
        test_halt();
        test_interrupt();
        test_halt_to_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
